// File: rtl/vga_fb_fetch_arbiter_if.sv
// Bus bundle between the framebuffer fetch arbiter and its environment:
// sync counters, CPU requester, single-port RAM and line-buffer write port.
interface vga_fb_fetch_arbiter_if #(
    parameter int unsigned ADDR_W = 19,
    parameter int unsigned LB_AW  = 9
);
    logic [10:0]       hc;
    logic [10:0]       vc;
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [31:0]       cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_rvalid;
    logic [31:0]       cpu_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              lb_we;
    logic [LB_AW-1:0]  lb_addr;
    logic [31:0]       lb_wdata;
    logic              fetch_busy;
    logic              underrun;

    modport master (
        input  hc, vc, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata, mem_en, mem_we, mem_addr,
        output mem_wdata, lb_we, lb_addr, lb_wdata, fetch_busy, underrun
    );

    modport slave (
        output hc, vc, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata, mem_en, mem_we, mem_addr,
        input  mem_wdata, lb_we, lb_addr, lb_wdata, fetch_busy, underrun
    );
endinterface

// File: rtl/vga_fb_fetch_arbiter.sv
// Prefetches each visible line into the line buffer and lends the framebuffer RAM
// to the CPU when idle. `define VGA_ARB_CPU_SLOT_EN to give the CPU every 4th fetch cycle.
module vga_fb_fetch_arbiter #(
    parameter int unsigned ACTIVE_H_VIDEO = 1280,
    parameter int unsigned BLACK_H        = 432,
    parameter int unsigned BLACK_V        = 34,
    parameter int unsigned PIX_PER_WORD   = 4,
    parameter int unsigned ADDR_W         = 19,
    parameter int unsigned LB_AW          = 9,
    parameter int unsigned FB_BASE        = 0,
    parameter int unsigned FETCH_START    = 0
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    vga_fb_fetch_arbiter_if.master bus
);
    localparam int unsigned WORDS_PER_LINE = ACTIVE_H_VIDEO / PIX_PER_WORD;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_WAIT} state_t;

    state_t            state, state_nxt;
    logic [LB_AW-1:0]  idx, idx_nxt;
    logic [ADDR_W-1:0] line_base, line_base_nxt;
    logic              lb_pend;
    logic [LB_AW-1:0]  lb_idx;
    logic              cpu_rd_pend;
    logic [31:0]       rdata_hold;
    logic              trigger, abort, slot, issue, gnt, last_issue;

`ifdef VGA_ARB_CPU_SLOT_EN
    logic [1:0]        fcnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fcnt <= '0;
        end else if (trigger) begin
            fcnt <= '0;
        end else if (state == S_FETCH) begin
            fcnt <= fcnt + 2'd1;
        end
    end

    assign slot = (state == S_FETCH) && (fcnt == 2'd3) && bus.cpu_req && !abort;
`else
    assign slot = 1'b0;
`endif

    always_comb begin
        trigger    = (state == S_IDLE) && (bus.hc == 11'(FETCH_START)) && (bus.vc >= 11'(BLACK_V));
        abort      = ((state == S_FETCH) || (state == S_DRAIN)) && (bus.hc == 11'(BLACK_H - 1));
        issue      = (state == S_FETCH) && !abort && !slot;
        last_issue = issue && (idx == LB_AW'(WORDS_PER_LINE - 1));
        // Grant is gated by reset so the combinational outputs are quiet while rst_i is high.
        gnt        = !rst_i && bus.cpu_req &&
                     (((state == S_IDLE) && !trigger) || (state == S_WAIT) || slot);
    end

    always_comb begin
        state_nxt     = state;
        idx_nxt       = idx;
        line_base_nxt = line_base;
        case (state)
            S_IDLE:  if (trigger) state_nxt = S_FETCH;
            S_FETCH: if (abort) state_nxt = S_WAIT;
                     else if (last_issue) state_nxt = S_DRAIN;
            S_DRAIN: state_nxt = S_WAIT;
            S_WAIT:  if (bus.hc != 11'(FETCH_START)) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (trigger) begin
            idx_nxt = '0;
        end else if (issue) begin
            idx_nxt = idx + 1'b1;
        end
        if (bus.vc < 11'(BLACK_V)) begin
            line_base_nxt = ADDR_W'(FB_BASE);
        end else if ((state == S_DRAIN) || abort) begin
            line_base_nxt = line_base + ADDR_W'(WORDS_PER_LINE);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= S_IDLE;
            idx         <= '0;
            line_base   <= ADDR_W'(FB_BASE);
            lb_pend     <= 1'b0;
            lb_idx      <= '0;
            cpu_rd_pend <= 1'b0;
            rdata_hold  <= '0;
        end else begin
            state       <= state_nxt;
            idx         <= idx_nxt;
            line_base   <= line_base_nxt;
            lb_pend     <= issue;
            lb_idx      <= idx;
            cpu_rd_pend <= gnt && !bus.cpu_we;
            if (cpu_rd_pend) begin
                rdata_hold <= bus.mem_rdata;
            end
        end
    end

    always_comb begin
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (issue) begin
            bus.mem_en   = 1'b1;
            bus.mem_addr = line_base + ADDR_W'(idx);
        end else if (gnt) begin
            bus.mem_en    = 1'b1;
            bus.mem_we    = bus.cpu_we;
            bus.mem_addr  = bus.cpu_addr;
            bus.mem_wdata = bus.cpu_wdata;
        end
    end

    // Read data is registered in the RAM, so both return paths pass mem_rdata straight through.
    always_comb begin
        bus.cpu_gnt    = gnt;
        bus.cpu_rvalid = cpu_rd_pend;
        bus.cpu_rdata  = cpu_rd_pend ? bus.mem_rdata : rdata_hold;
        bus.lb_we      = lb_pend;
        bus.lb_addr    = lb_idx;
        bus.lb_wdata   = lb_pend ? bus.mem_rdata : '0;
        bus.fetch_busy = (state == S_FETCH) || (state == S_DRAIN);
        bus.underrun   = abort;
    end
endmodule
